dmem_responder: RTL and testbench

Data-memory responder that terminates the MEM-stage load/store interface of the RV32IC pipeline. It accepts one request per handshake from the memory stage (read/write strobes, size/sign type, ALU-computed address, rs2 store data) and performs byte-lane steering into a word-organized synchronous RAM. It returns sign- or zero-extended load data to the write-back path. Requests that cross a word boundary are split into two RAM cycles, and the pipeline is stalled through `req_ready` while the split is in progress.

---
 rtl/dmem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane steering into a word RAM with load extension.
// Define DMEM_MISALIGN_EN to split word-crossing accesses over two cycles; otherwise misaligned accesses fault.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_read_i,
    input  logic        req_write_i,
    input  logic [3:0]  req_type_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [1:0]  size_s;
    logic [1:0]  offset_s;
    logic [2:0]  nbytes_s;
    logic [3:0]  mask_s;
    logic [32:0] rel_s;
    logic [32:0] end_rel_s;
    logic        in_range_s;
    logic        misalign_s;
    logic        fault_s;
    logic        accept_s;
    logic [AW-1:0] idx_s;
    logic [31:0] rd_lo_s;
    logic [31:0] lo_data_s;
    logic [3:0]  lo_mask_s;
    logic        wr_lo_s;

    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    // Shift the addressed bytes down to bit 0, then sign- or zero-extend by size.
    function automatic logic [31:0] fmt_load(input logic [63:0] pair, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'b00:   fmt_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    // Request decode: size, lane mask, range and fault classification.
    always_comb begin
        size_s   = req_type_i[1:0];
        offset_s = req_addr_i[1:0];
        case (size_s)
            2'b00:   begin nbytes_s = 3'd1; mask_s = 4'b0001; end
            2'b01:   begin nbytes_s = 3'd2; mask_s = 4'b0011; end
            2'b10:   begin nbytes_s = 3'd4; mask_s = 4'b1111; end
            default: begin nbytes_s = 3'd1; mask_s = 4'b0000; end
        endcase
        rel_s      = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
        end_rel_s  = rel_s + {30'h0, nbytes_s} - 33'd1;
        in_range_s = !rel_s[32] && (end_rel_s < 33'(4 * DEPTH_WORDS));
        misalign_s = ((size_s == 2'b01) && offset_s[0]) || ((size_s == 2'b10) && (offset_s != 2'b00));
        fault_s    = (req_read_i == req_write_i) || (size_s == 2'b11) || req_type_i[3] || !in_range_s;
`ifndef DMEM_MISALIGN_EN
        fault_s    = fault_s || misalign_s;
`endif
        idx_s      = AW'(rel_s >> 2);
    end

    assign rd_lo_s = mem_q[idx_s];

`ifdef DMEM_MISALIGN_EN
    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
    state_t        state_q, state_d;
    logic [63:0]   wide_data_s;
    logic [7:0]    wide_mask_s;
    logic          crossing_s;
    logic          cap_s;
    logic          wr_hi_s;
    logic [31:0]   rd_hi_s;
    logic [AW-1:0] hi_idx_q;
    logic [31:0]   hi_data_q;
    logic [3:0]    hi_mask_q;
    logic [31:0]   lo_word_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          split_wr_q;

    assign wide_data_s = {32'h0000_0000, req_wdata_i} << {offset_s, 3'b000};
    assign wide_mask_s = {4'h0, mask_s} << offset_s;
    assign lo_data_s   = wide_data_s[31:0];
    assign lo_mask_s   = wide_mask_s[3:0];
    assign crossing_s  = ({1'b0, offset_s} + nbytes_s) > 3'd4;
    assign req_ready_o = (state_q == IDLE);
    assign rd_hi_s     = mem_q[hi_idx_q];
    assign wr_hi_s     = (state_q == SPLIT) && split_wr_q && !rst;
`else
    assign lo_data_s   = req_wdata_i << {offset_s, 3'b000};
    assign lo_mask_s   = mask_s << offset_s;
    assign req_ready_o = 1'b1;
`endif

    assign accept_s = req_valid_i && req_ready_o;
    assign wr_lo_s  = accept_s && !fault_s && req_write_i && !rst;

    // Next state and response formation.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;
`ifdef DMEM_MISALIGN_EN
        state_d = state_q;
        cap_s   = 1'b0;
        if (state_q == SPLIT) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b0;
            resp_rdata_d = split_wr_q ? 32'h0000_0000 : fmt_load({rd_hi_s, lo_word_q}, off_q, size_q, uns_q);
        end else
`endif
        if (accept_s) begin
            if (fault_s) begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
                resp_rdata_d = 32'h0000_0000;
            end
`ifdef DMEM_MISALIGN_EN
            else if (crossing_s) begin
                state_d = SPLIT;
                cap_s   = 1'b1;
            end
`endif
            else begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = req_read_i ? fmt_load({32'h0000_0000, rd_lo_s}, offset_s, size_s, req_type_i[2])
                                          : 32'h0000_0000;
            end
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
`ifdef DMEM_MISALIGN_EN
            state_q    <= IDLE;
            hi_idx_q   <= '0;
            hi_data_q  <= 32'h0000_0000;
            hi_mask_q  <= 4'h0;
            lo_word_q  <= 32'h0000_0000;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            split_wr_q <= 1'b0;
`endif
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_MISALIGN_EN
            state_q <= state_d;
            if (cap_s) begin
                hi_idx_q   <= idx_s + AW'(1);
                hi_data_q  <= wide_data_s[63:32];
                hi_mask_q  <= wide_mask_s[7:4];
                lo_word_q  <= rd_lo_s;
                off_q      <= offset_s;
                size_q     <= size_s;
                uns_q      <= req_type_i[2];
                split_wr_q <= req_write_i;
            end
`endif
        end
    end

    // Byte-enabled RAM writes; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lo_s && lo_mask_s[b]) begin
                mem_q[idx_s][8*b +: 8] <= lo_data_s[8*b +: 8];
            end
`ifdef DMEM_MISALIGN_EN
            if (wr_hi_s && hi_mask_q[b]) begin
                mem_q[hi_idx_q][8*b +: 8] <= hi_data_q[8*b +: 8];
            end
`endif
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_fault_o = resp_fault_q;
    assign resp_rdata_o = resp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder; expectations follow both builds of DMEM_MISALIGN_EN.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [3:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] r_data;
    logic        r_fault;
    int          r_lat;
    logic        r_rdy;

    localparam logic [3:0] T_B = 4'b0000, T_H = 4'b0001, T_W = 4'b0010, T_BU = 4'b0100, T_HU = 4'b0101;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_read_i(req_read), .req_write_i(req_write),
        .req_type_i(req_type), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then wait (bounded) for its response.
    task automatic txn(input logic rd, input logic wr, input logic [3:0] typ, input logic [31:0] addr,
                       input logic [31:0] wd);
        req_read = rd; req_write = wr; req_type = typ; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        r_rdy = req_ready;
        r_lat = 1;
        while (!resp_valid && r_lat < 5) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_data  = resp_rdata;
        r_fault = resp_fault;
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] wd);
        txn(1'b0, 1'b1, T_W, addr, wd);
        chk("sw_fault", {31'h0, r_fault}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_type = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", {31'h0, resp_fault}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned word store then load.
        txn(1'b0, 1'b1, T_W, 32'h10, 32'hDEAD_BEEF);
        chk("sw10_lat", r_lat, 32'd1);
        chk("sw10_rdy", {31'h0, r_rdy}, 32'h1);
        chk("sw10_rdata", r_data, 32'h0);
        @(posedge clk); #1;
        chk("pulse_once", {31'h0, resp_valid}, 32'h0);
        txn(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10", r_data, 32'hDEAD_BEEF);
        chk("lw10_lat", r_lat, 32'd1);
        chk("lw10_fault", {31'h0, r_fault}, 32'h0);

        // Byte / half extension.
        sw(32'h20, 32'h80FF_7F01);
        txn(1'b1, 1'b0, T_B,  32'h22, 32'h0); chk("lb22", r_data, 32'hFFFF_FFFF);
        txn(1'b1, 1'b0, T_BU, 32'h23, 32'h0); chk("lbu23", r_data, 32'h0000_0080);
        txn(1'b1, 1'b0, T_B,  32'h20, 32'h0); chk("lb20", r_data, 32'h0000_0001);
        txn(1'b1, 1'b0, T_BU, 32'h21, 32'h0); chk("lbu21", r_data, 32'h0000_007F);
        txn(1'b1, 1'b0, T_H,  32'h22, 32'h0); chk("lh22", r_data, 32'hFFFF_80FF);
        txn(1'b1, 1'b0, T_HU, 32'h22, 32'h0); chk("lhu22", r_data, 32'h0000_80FF);
        txn(1'b1, 1'b0, T_H,  32'h20, 32'h0); chk("lh20", r_data, 32'h0000_7F01);

        // Halfword at offset 1.
        sw(32'h30, 32'h0);
        txn(1'b0, 1'b1, T_H, 32'h31, 32'h1234_ABCD);
`ifdef DMEM_MISALIGN_EN
        chk("sh31_fault", {31'h0, r_fault}, 32'h0);
        chk("sh31_lat", r_lat, 32'd1);
        txn(1'b1, 1'b0, T_W, 32'h30, 32'h0); chk("lw30", r_data, 32'h00AB_CD00);
        txn(1'b1, 1'b0, T_H, 32'h31, 32'h0); chk("lh31", r_data, 32'hFFFF_ABCD);
`else
        chk("sh31_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b1, 1'b0, T_W, 32'h30, 32'h0); chk("lw30", r_data, 32'h0000_0000);
`endif
        txn(1'b0, 1'b1, T_B, 32'h33, 32'h0000_0077);
        txn(1'b1, 1'b0, T_BU, 32'h33, 32'h0); chk("lbu33", r_data, 32'h0000_0077);

        // Word-crossing load.
        sw(32'h40, 32'h3322_1100);
        sw(32'h44, 32'h7766_5544);
        txn(1'b1, 1'b0, T_W, 32'h42, 32'h0);
`ifdef DMEM_MISALIGN_EN
        chk("lw42_rdy", {31'h0, r_rdy}, 32'h0);
        chk("lw42_lat", r_lat, 32'd2);
        chk("lw42", r_data, 32'h5544_3322);
        chk("lw42_fault", {31'h0, r_fault}, 32'h0);
        @(posedge clk); #1;
        chk("split_pulse_once", {31'h0, resp_valid}, 32'h0);
        txn(1'b0, 1'b1, T_H, 32'h43, 32'h0000_BEEF);
        chk("sh43_lat", r_lat, 32'd2);
        txn(1'b1, 1'b0, T_W, 32'h40, 32'h0); chk("lw40_after_sh43", r_data, 32'hEF22_1100);
        txn(1'b1, 1'b0, T_W, 32'h44, 32'h0); chk("lw44_after_sh43", r_data, 32'h7766_55BE);
        txn(1'b1, 1'b0, T_HU, 32'h43, 32'h0); chk("lhu43", r_data, 32'h0000_BEEF);
`else
        chk("lw42_fault", {31'h0, r_fault}, 32'h1);
        chk("lw42_lat", r_lat, 32'd1);
        chk("lw42_rdata", r_data, 32'h0);
        txn(1'b0, 1'b1, T_W, 32'h42, 32'hFFFF_FFFF);
        chk("sw42_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b1, 1'b0, T_W, 32'h40, 32'h0); chk("lw40_kept", r_data, 32'h3322_1100);
        txn(1'b1, 1'b0, T_W, 32'h44, 32'h0); chk("lw44_kept", r_data, 32'h7766_5544);
`endif

        // Fault cases and boundaries.
        txn(1'b1, 1'b0, T_W, 32'h1000, 32'h0);
        chk("oob_fault", {31'h0, r_fault}, 32'h1);
        chk("oob_rdata", r_data, 32'h0);
        txn(1'b1, 1'b1, T_W, 32'h10, 32'h0BAD_0BAD);
        chk("rdwr_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b0, 1'b0, T_W, 32'h10, 32'h0);
        chk("none_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b1, 1'b0, 4'b0011, 32'h10, 32'h0);
        chk("size3_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b1, 1'b0, 4'b1010, 32'h10, 32'h0);
        chk("rsv_fault", {31'h0, r_fault}, 32'h1);
        txn(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10_after_faults", r_data, 32'hDEAD_BEEF);
        chk("lw10_after_faults_f", {31'h0, r_fault}, 32'h0);
        sw(32'hFFC, 32'hCAFE_F00D);
        txn(1'b1, 1'b0, T_W, 32'hFFC, 32'h0); chk("lw_top", r_data, 32'hCAFE_F00D);
        txn(1'b1, 1'b0, T_BU, 32'hFFF, 32'h0); chk("lbu_top", r_data, 32'h0000_00CA);
        txn(1'b1, 1'b0, T_H, 32'hFFF, 32'h0);
        chk("lh_top_fault", {31'h0, r_fault}, 32'h1);
        chk("lh_top_lat", r_lat, 32'd1);

`ifdef DMEM_MISALIGN_EN
        // Reset during the second half of a crossing store.
        sw(32'h4C, 32'h0);
        sw(32'h50, 32'h0);
        req_read = 1'b0; req_write = 1'b1; req_type = T_W; req_addr = 32'h4E; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
        chk("split_rdy_low", {31'h0, req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_split_rdy", {31'h0, req_ready}, 32'h1);
        chk("rst_split_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("rst_split_valid2", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_split_valid3", {31'h0, resp_valid}, 32'h0);
        txn(1'b1, 1'b0, T_W, 32'h4C, 32'h0); chk("lw4c_after_rst", r_data, 32'h3344_0000);
        txn(1'b1, 1'b0, T_W, 32'h50, 32'h0); chk("lw50_after_rst", r_data, 32'h0000_0000);
`else
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mid_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, T_W, 32'h20, 32'h0); chk("lw20_after_rst", r_data, 32'h80FF_7F01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
